// File: rtl/tlv5618_dac_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tlv5618_dac_scheduler
// Purpose  : Two-channel request scheduler for the TLV5618 serial-DAC driver.
//            Arbitrates channel A/B update requests round-robin, formats the
//            16-bit TLV5618 command word and issues it through the driver's
//            set_data/set_go/set_done handshake, with a minimum idle gap
//            after every completed (or aborted) word.
// Optional : `define TLV5618_SYNC_UPDATE_EN to accept simultaneous A+B
//            requests as one two-word transaction (B buffered, then A written
//            so both outputs update together).
// Ports    : clk            system clock
//            rst_n          asynchronous active-low reset
//            a_valid/a_data/a_ready   channel A request (ready = 1-cycle pulse)
//            b_valid/b_data/b_ready   channel B request (ready = 1-cycle pulse)
//            pwr_dn         power-down bit, sampled at acceptance
//            dac_set_data   command word to the driver
//            dac_set_go     one-cycle start pulse to the driver
//            dac_set_done   one-cycle completion pulse from the driver
//            busy           high from first go through end of last gap
//            timeout_err    one-cycle pulse when the done wait expires
// Revision : 1.0 - initial release
// ============================================================================
module tlv5618_dac_scheduler #(
  parameter logic        FAST_MODE    = 1'b1,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned DONE_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [11:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [11:0] b_data,
  output logic        b_ready,
  input  logic        pwr_dn,
  output logic [15:0] dac_set_data,
  output logic        dac_set_go,
  input  logic        dac_set_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_send = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;
  localparam logic [1:0] c_st_gap  = 2'd3;

  localparam logic [15:0] c_timeout = 16'(DONE_TIMEOUT);
  localparam logic [15:0] c_gap     = 16'(GAP_CYCLES);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_ptr_b;       // 0: A wins a tie, 1: B wins a tie
  logic [15:0] r_cnt;         // WAIT: cycles since go; GAP: gap cycles elapsed
  logic        r_pend;        // second word of a synchronous update waiting
  logic [15:0] r_pend_word;

  logic        w_both;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_expired;
  logic        w_gap_end;
  logic [15:0] w_word_a;
  logic [15:0] w_word_b;
  logic [15:0] w_word_b_buf;

  // Simultaneous-request handling: with the sync feature both channels are
  // taken together; otherwise the pointer alone resolves the tie.
`ifdef TLV5618_SYNC_UPDATE_EN
  assign w_both = a_valid & b_valid;
`else
  assign w_both = 1'b0;
`endif

  assign w_grant_a = a_valid & (~b_valid | ~r_ptr_b);
  assign w_grant_b = b_valid & ~w_grant_a;

  // D15=R1, D14=SPD, D13=PWR, D12=R0, D11:0=code
  assign w_word_a     = {1'b1, FAST_MODE, pwr_dn, 1'b0, a_data};
  assign w_word_b     = {1'b0, FAST_MODE, pwr_dn, 1'b0, b_data};
  assign w_word_b_buf = {1'b0, FAST_MODE, pwr_dn, 1'b1, b_data};

  assign w_expired = (r_cnt == c_timeout);
  assign w_gap_end = (r_cnt == c_gap);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (a_valid || b_valid) begin
          w_state_next = c_st_send;
        end
      end
      c_st_send: begin
        w_state_next = c_st_wait;
      end
      c_st_wait: begin
        // A done coinciding with expiry is still a success.
        if (dac_set_done || w_expired) begin
          w_state_next = c_st_gap;
        end
      end
      c_st_gap: begin
        if (w_gap_end) begin
          w_state_next = r_pend ? c_st_send : c_st_idle;
        end
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // Output logic
  always_comb begin
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    dac_set_go  = 1'b0;
    timeout_err = 1'b0;
    busy        = (r_state != c_st_idle);
    case (r_state)
      c_st_idle: begin
        // Ready is combinational on valid, so it is masked while reset is
        // asserted to keep the handshake quiet.
        a_ready = rst_n & (w_grant_a | w_both);
        b_ready = rst_n & (w_grant_b | w_both);
      end
      c_st_send: begin
        dac_set_go = 1'b1;
      end
      c_st_wait: begin
        timeout_err = w_expired & ~dac_set_done;
      end
      default: begin
      end
    endcase
  end

  // Datapath: command word, pending second word, pointer and shared counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_set_data <= 16'h0000;
      r_ptr_b      <= 1'b0;
      r_cnt        <= 16'd0;
      r_pend       <= 1'b0;
      r_pend_word  <= 16'h0000;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_cnt <= 16'd0;
          if (w_both) begin
            // Buffer B first, then write A to update both outputs at once.
            // The pointer is left alone since neither channel was favoured.
            dac_set_data <= w_word_b_buf;
            r_pend       <= 1'b1;
            r_pend_word  <= w_word_a;
          end else if (w_grant_a) begin
            dac_set_data <= w_word_a;
            r_ptr_b      <= 1'b1;
          end else if (w_grant_b) begin
            dac_set_data <= w_word_b;
            r_ptr_b      <= 1'b0;
          end
        end
        c_st_send: begin
          // First WAIT cycle is one cycle after go.
          r_cnt <= 16'd1;
        end
        c_st_wait: begin
          if (dac_set_done || w_expired) begin
            r_cnt <= 16'd1;
            if (!dac_set_done) begin
              r_pend <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_st_gap: begin
          if (w_gap_end) begin
            r_cnt <= 16'd0;
            if (r_pend) begin
              dac_set_data <= r_pend_word;
              r_pend       <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_cnt <= 16'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlv5618_dac_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tlv5618_dac_scheduler
// Purpose  : Self-checking bench for tlv5618_dac_scheduler. A transaction
//            timeline model (accept time, go time, done/deadline windows)
//            predicts every output each cycle; directed sequences pin the
//            model with literal expectations; a randomized phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlv5618_dac_scheduler;

  localparam int   G   = 4;
  localparam int   DT  = 20;
  localparam logic SPD = 1'b1;
`ifdef TLV5618_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic [11:0] a_data = 12'h000;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [11:0] b_data = 12'h000;
  logic        b_ready;
  logic        pwr_dn = 1'b0;
  logic [15:0] dac_set_data;
  logic        dac_set_go;
  logic        dac_set_done = 1'b0;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  tlv5618_dac_scheduler #(
    .FAST_MODE   (SPD),
    .GAP_CYCLES  (G),
    .DONE_TIMEOUT(DT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .pwr_dn      (pwr_dn),
    .dac_set_data(dac_set_data),
    .dac_set_go  (dac_set_go),
    .dac_set_done(dac_set_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  bit          chk_en = 1'b0;
  bit          m_ptr_b = 1'b0;
  bit          m_active = 1'b0;
  bit          m_in_wait = 1'b0;
  int          m_go_at = -1;
  int          m_idle_at = -1;
  int          m_deadline = -1;
  logic [15:0] m_cur = 16'h0;
  logic [15:0] m_q[$];
  logic        e_ar, e_br, e_go, e_to, e_busy, e_chk_data;

  // done driver
  bit done_auto = 1'b0;
  bit spur = 1'b0;
  int auto_lat = 0;
  int done_at = -1;
  bit man_done = 1'b0;
  bit got_a = 1'b0;
  bit got_b = 1'b0;

  task automatic model_reset();
    m_ptr_b = 1'b0; m_active = 1'b0; m_in_wait = 1'b0;
    m_go_at = -1; m_idle_at = -1; m_deadline = -1;
    m_q.delete();
    done_at = -1;
  endtask

  always @(negedge clk) begin
    got_a = a_ready;
    got_b = b_ready;
    if (rst_n && chk_en) begin
      e_ar = 0; e_br = 0; e_go = 0; e_to = 0; e_chk_data = 0;
      if (m_active && cyc == m_idle_at) m_active = 1'b0;
      if (!m_active) begin
        e_busy = 0;
        if (a_valid || b_valid) begin
          if (SYNC && a_valid && b_valid) begin
            e_ar = 1; e_br = 1;
            m_q.push_back({1'b0, SPD, pwr_dn, 1'b1, b_data});
            m_q.push_back({1'b1, SPD, pwr_dn, 1'b0, a_data});
          end else if (a_valid && (!b_valid || !m_ptr_b)) begin
            e_ar = 1;
            m_q.push_back({1'b1, SPD, pwr_dn, 1'b0, a_data});
            m_ptr_b = 1'b1;
          end else begin
            e_br = 1;
            m_q.push_back({1'b0, SPD, pwr_dn, 1'b0, b_data});
            m_ptr_b = 1'b0;
          end
          m_active = 1'b1; m_go_at = cyc + 1; m_idle_at = -1; m_in_wait = 1'b0;
        end
      end else begin
        e_busy = 1;
        if (cyc == m_go_at) begin
          e_go = 1; e_chk_data = 1;
          m_cur = m_q.pop_front();
          m_in_wait = 1'b1; m_deadline = cyc + DT;
          if (done_auto) begin
            if (auto_lat > 0) done_at = cyc + auto_lat;
            else if ($urandom_range(0, 5) == 0) done_at = -1;
            else done_at = cyc + $urandom_range(1, 24);
          end
        end else if (m_in_wait) begin
          e_chk_data = 1;
          if (dac_set_done) begin
            m_in_wait = 1'b0;
            if (m_q.size() > 0) m_go_at = cyc + G + 1;
            else m_idle_at = cyc + G + 1;
          end else if (cyc == m_deadline) begin
            e_to = 1; m_in_wait = 1'b0;
            m_q.delete();
            m_idle_at = cyc + G + 1;
          end
        end
      end
      chk("a_ready", a_ready, e_ar);
      chk("b_ready", b_ready, e_br);
      chk("dac_set_go", dac_set_go, e_go);
      chk("timeout_err", timeout_err, e_to);
      chk("busy", busy, e_busy);
      if (e_chk_data) chk("dac_set_data", dac_set_data, m_cur);
    end
  end

  always @(posedge clk) begin
    #2;
    if (done_auto) dac_set_done = (cyc == done_at) || (spur && $urandom_range(0, 39) == 0);
    else dac_set_done = man_done;
  end

  // ---------------- helpers ----------------
  task automatic to_neg(input int c);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc >= c) return;
    end
  endtask

  task automatic pulse_done_at(input int c);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cyc >= c) begin
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_ready(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_ready || b_ready) begin
        t = cyc; ok = 1'b1;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL ready_wait: got no ready, expected one within 60 cycles");
  endtask

  task automatic single(input bit is_a, input logic [11:0] d, input bit p,
                        input logic [15:0] word, input int lat);
    int t; bit ok;
    @(posedge clk); #1;
    a_valid = is_a; b_valid = !is_a; pwr_dn = p;
    if (is_a) a_data = d; else b_data = d;
    wait_ready(t, ok);
    if (!ok) return;
    chk("ready_which", {14'd0, a_ready, b_ready}, is_a ? 16'd2 : 16'd1);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    to_neg(t + 1);
    chk("go_literal", dac_set_go, 1);
    chk("word_literal", dac_set_data, word);
    if (lat > 0) begin
      pulse_done_at(t + 1 + lat);
      to_neg(t + 1 + lat + G);
      chk("busy_end_gap", busy, 1);
      to_neg(t + lat + G + 2);
      chk("busy_fall", busy, 0);
    end else begin
      to_neg(t + DT);
      chk("timeout_early", timeout_err, 0);
      to_neg(t + 1 + DT);
      chk("timeout_fire", timeout_err, 1);
      to_neg(t + 1 + DT + G + 1);
      chk("busy_after_timeout", busy, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t; bit ok;
    #12;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_go", dac_set_go, 0);
    chk("rst_data", dac_set_data, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; chk_en = 1'b1;

    single(1'b1, 12'hABC, 1'b0, 16'hCABC, 14);
    single(1'b0, 12'h123, 1'b0, 16'h4123, 7);
    single(1'b0, 12'h123, 1'b1, 16'h6123, 20);  // done on the expiry cycle
    single(1'b1, 12'h3C5, 1'b0, 16'hC3C5, 0);   // no done: timeout
    single(1'b1, 12'h555, 1'b1, 16'hE555, 3);

    // Reset in the middle of WAIT with both channels requesting.
    @(posedge clk); #1;
    a_valid = 1'b1; a_data = 12'h111; b_valid = 1'b0; pwr_dn = 1'b0;
    wait_ready(t, ok);
    @(posedge clk); #1;
    a_valid = 1'b0;
    to_neg(t + 3);
    @(posedge clk); #1;
    a_valid = 1'b1; b_valid = 1'b1; a_data = 12'h800; b_data = 12'h400;
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_a_ready", a_ready, 0);
    chk("rstw_b_ready", b_ready, 0);
    chk("rstw_go", dac_set_go, 0);
    chk("rstw_data", dac_set_data, 16'h0000);
    chk("rstw_busy", busy, 0);
    chk("rstw_timeout", timeout_err, 0);
    model_reset();
    done_auto = 1'b1; auto_lat = 3; spur = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready(t, ok);
    if (ok) begin
      if (SYNC) begin
        chk("sync_both_ready", {14'd0, a_ready, b_ready}, 16'd3);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        to_neg(t + 1);
        chk("sync_word1", dac_set_data, 16'h5400);
        to_neg(t + 8);
        chk("sync_gap_nogo", dac_set_go, 0);
        to_neg(t + 9);
        chk("sync_word2_go", dac_set_go, 1);
        chk("sync_word2", dac_set_data, 16'hC800);
      end else begin
        chk("rr_grant1_A", {14'd0, a_ready, b_ready}, 16'd2);
        to_neg(t + 9);
        chk("rr_grant2_B", {14'd0, a_ready, b_ready}, 16'd1);
        to_neg(t + 18);
        chk("rr_grant3_A", {14'd0, a_ready, b_ready}, 16'd2);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Randomized traffic with random done latency, timeouts and stray dones.
    auto_lat = 0; spur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (got_a || !a_valid) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_data = 12'($urandom);
      end
      if (got_b || !b_valid) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_data = 12'($urandom);
      end
      pwr_dn = 1'($urandom);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (60) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
